mux16_1: RTL and testbench



---
 rtl/mux16_1.sv | 98 +++++++++
 tb/tb_mux16_1.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mux16_1.sv
// mux16_1: registered 16-to-1 single-bit multiplexer.
// sel = {s3,s2,s1,s0} picks one of i0..i15; the chosen bit is captured in y on
// every rising edge of clk. rst_n clears y asynchronously.
// Optional build macro: MUX16_1_SEL_REG_EN registers the select lines first
// (select-to-y latency 2 cycles, data-to-y latency stays 1 cycle).
module mux16_1 (
    input  logic clk,
    input  logic rst_n,
    input  logic i0,
    input  logic i1,
    input  logic i2,
    input  logic i3,
    input  logic i4,
    input  logic i5,
    input  logic i6,
    input  logic i7,
    input  logic i8,
    input  logic i9,
    input  logic i10,
    input  logic i11,
    input  logic i12,
    input  logic i13,
    input  logic i14,
    input  logic i15,
    input  logic s0,
    input  logic s1,
    input  logic s2,
    input  logic s3,
    output logic y
);

    logic [15:0] data_s;
    logic [3:0]  sel_in_s;
    logic [3:0]  sel_s;
    logic        d_s;

    // Full 16-way decode of one bit; every code maps to exactly one input.
    function automatic logic pick_bit(input logic [15:0] data, input logic [3:0] sel);
        logic bit_v;
        case (sel)
            4'd0:    bit_v = data[0];
            4'd1:    bit_v = data[1];
            4'd2:    bit_v = data[2];
            4'd3:    bit_v = data[3];
            4'd4:    bit_v = data[4];
            4'd5:    bit_v = data[5];
            4'd6:    bit_v = data[6];
            4'd7:    bit_v = data[7];
            4'd8:    bit_v = data[8];
            4'd9:    bit_v = data[9];
            4'd10:   bit_v = data[10];
            4'd11:   bit_v = data[11];
            4'd12:   bit_v = data[12];
            4'd13:   bit_v = data[13];
            4'd14:   bit_v = data[14];
            4'd15:   bit_v = data[15];
            default: bit_v = 1'b0;
        endcase
        return bit_v;
    endfunction

    assign data_s   = {i15, i14, i13, i12, i11, i10, i9, i8,
                       i7,  i6,  i5,  i4,  i3,  i2,  i1, i0};
    assign sel_in_s = {s3, s2, s1, s0};

`ifdef MUX16_1_SEL_REG_EN
    logic [3:0] sel_r;

    // Select register: decouples the select path from the data path by one stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r <= 4'd0;
        end else begin
            sel_r <= sel_in_s;
        end
    end

    assign sel_s = sel_r;
`else
    assign sel_s = sel_in_s;
`endif

    // Next-state selection of the output bit from the live data inputs.
    always_comb begin
        d_s = 1'b0;
        d_s = pick_bit(data_s, sel_s);
    end

    // Output flop: samples the selected bit every edge, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= 1'b0;
        end else begin
            y <= d_s;
        end
    end

endmodule

// File: tb/tb_mux16_1.sv
// Self-checking bench for mux16_1. Expected values come from a small reference
// model (with an optional select-register stage) and flow through a queue.
module tb_mux16_1;

    logic        clk;
    logic        rst_n;
    logic [15:0] din;
    logic [3:0]  sel;
    logic        y;

    int checks;
    int failures;

    // Reference pattern i0..i15 = 0,1,0,1,0,1,1,0,1,0,1,1,1,0,1,0
    localparam logic [15:0] PAT = 16'h5D6A;

    logic       exp_q[$];
    logic [3:0] model_sel_r;

    mux16_1 dut (
        .clk  (clk),
        .rst_n(rst_n),
        .i0 (din[0]),  .i1 (din[1]),  .i2 (din[2]),  .i3 (din[3]),
        .i4 (din[4]),  .i5 (din[5]),  .i6 (din[6]),  .i7 (din[7]),
        .i8 (din[8]),  .i9 (din[9]),  .i10(din[10]), .i11(din[11]),
        .i12(din[12]), .i13(din[13]), .i14(din[14]), .i15(din[15]),
        .s0 (sel[0]),  .s1 (sel[1]),  .s2 (sel[2]),  .s3 (sel[3]),
        .y  (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic expected);
        checks++;
        assert (y === expected) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, y, expected);
        end
    endtask

    // Drive one select/data pair, predict y after the next edge, then compare.
    task automatic step(input string tag, input logic [3:0] s, input logic [15:0] d);
        logic e;
        logic [15:0] dv;
        sel = s;
        din = d;
        dv  = d;
`ifdef MUX16_1_SEL_REG_EN
        e = dv[model_sel_r];
        model_sel_r = s;
`else
        e = dv[s];
`endif
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check(tag, exp_q.pop_front());
    endtask

    initial begin
        logic [15:0] d;
        checks      = 0;
        failures    = 0;
        model_sel_r = 4'd0;
        rst_n       = 1'b0;
        sel         = 4'd7;
        din         = 16'hFFFF;

        // Reset held low with y-selecting inputs at 1: y must stay 0.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("reset_hold", 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed select sweep.
        step("sel_0000", 4'b0000, PAT);
        step("sel_1000", 4'b1000, PAT);
        step("sel_0100", 4'b0100, PAT);
        step("sel_1100", 4'b1100, PAT);
        step("sel_0010", 4'b0010, PAT);
        step("sel_0001", 4'b0001, PAT);
        step("sel_1111", 4'b1111, PAT);

        // Full sweep of all codes in ascending order.
        for (int k = 0; k < 16; k++) begin
            step($sformatf("sweep_%0d", k), 4'(k), PAT);
        end

        // Data isolation: only i5 matters while sel = 5.
        step("iso_settle", 4'd5, PAT);
        d = PAT;
        for (int k = 0; k < 4; k++) begin
            d = d ^ 16'hFFDF;
            step($sformatf("iso_other_%0d", k), 4'd5, d);
        end
        d = d ^ 16'h0020;
        step("iso_i5_low", 4'd5, d);
        d = d ^ 16'h0020;
        step("iso_i5_high", 4'd5, d);

        // Simultaneous select and data change.
        step("simul_pre", 4'd3, PAT);
        step("simul_13", 4'd13, PAT | 16'h2000);
        step("simul_hold", 4'd13, PAT | 16'h2000);

        // Select step 0 -> 8 then flip i8.
        step("s08_a", 4'd0, PAT);
        step("s08_b", 4'd0, PAT);
        step("s08_c", 4'd8, PAT);
        step("s08_d", 4'd8, PAT);
        step("s08_flip", 4'd8, PAT ^ 16'h0100);
        step("s08_flip2", 4'd8, PAT);

        // Asynchronous reset between edges while y = 1.
        step("pre_async", 4'd8, PAT);
        step("pre_async2", 4'd8, PAT);
        check("pre_async_is_one", 1'b1);
        #1;
        rst_n = 1'b0;
        model_sel_r = 4'd0;
        #1;
        check("async_reset_drop", 1'b0);
        @(posedge clk);
        #1;
        check("async_reset_hold", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // First cycles after release; i0 = 1 so the select-register reset is visible.
        step("post_rel_a", 4'd2, PAT | 16'h0001);
        step("post_rel_b", 4'd2, PAT | 16'h0001);
        step("post_rel_c", 4'd1, PAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
